rv32i_pipeline_controlpath: RTL and testbench
=============================================

Name: rv32i_pipeline_controlpath

Overview:
- Control path for the 4-stage RV32I pipeline datapath (DEC, EXEC, MEM, WB; fetch is the PC/imem access feeding DEC).
- Decodes the DEC-stage instruction and drives the DEC mux selects directly.
- Carries per-instruction control fields down the EXEC/MEM/WB register chain.
- Detects RAW hazards (no forwarding) and inserts bubbles; resolves jumps in DEC and branches in EXEC, squashing wrong-path instructions.

Parameters:
- RESET_PC_SEL, SEL_PC_PLUS_4, pc_next_sel_o value driven while in reset.

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  asynchronous reset, active-low
- instruction_i  in  32  DEC-stage instruction from datapath
- alu_zero_i  in  1  ALU result zero (EXEC)
- alu_lt_i  in  1  signed less-than (EXEC)
- alu_ltu_i  in  1  unsigned less-than (EXEC)
- fetch_nop_o  out  1  replace fetched instruction with NOP (0x00000013)
- stall_dec_o  out  1  freeze PC and DEC register
- stall_exec_o  out  1  freeze EXEC/MEM/WB registers; constant 0, reserved for memory wait states
- pc_next_sel_o  out  3  SEL_PC_PLUS_4/JAL/JALR/BRANCH
- alu_src1_o  out  2  SEL_OP1_RS1/IMM/PC
- alu_src2_o  out  1  SEL_OP2_RS2/IMM
- imm_gen_sel_o  out  3  immediate format for DEC instruction
- alu_control_o  out  4  ALU function, EXEC-stage register
- dmem_we_o  out  1  data memory write, MEM-stage register
- wb_sel_o  out  2  SEL_WB_ALU/MEM/PC_PLUS_4, WB-stage register
- rd_add_o  out  5  destination register, WB-stage register
- reg_we_o  out  1  regfile write enable, WB-stage register

Behaviour:
- Reset: all EXEC/MEM/WB control registers are bubbles (we=0, dmem_we=0, is_branch=0, rd=0, alu=ALU_ADD, wb_sel=SEL_WB_ALU).
  - Reset outputs: dmem_we_o=0, reg_we_o=0, rd_add_o=0, alu_control_o=ALU_ADD, stall_exec_o=0.
  - Reset outputs: pc_next_sel_o=RESET_PC_SEL, stall_dec_o=0, fetch_nop_o=0.
- Decode (combinational, DEC): opcode/func3/func7 produce ctrl bundle {alu, src1, src2, imm_sel, we, dmem_we, wb_sel, is_branch, is_jal, is_jalr, uses_rs1, uses_rs2}.
  - Illegal or zero opcode decodes as NOP (no write, no memory access, no redirect).
  - LUI: src1=IMM, alu=ALU_COPY1.
  - AUIPC: src1=PC, src2=IMM, ADD.
  - JAL/JALR: wb_sel=PC_PLUS_4.
  - Loads: wb_sel=MEM, src2=IMM, imm I.
  - Stores: dmem_we=1, imm S.
  - Branches: alu=SUB, imm SB.
- Hazard: hz=1 when the DEC instruction uses rs1 (or rs2), that register is !=0, and it equals rd of any EXEC, MEM or WB entry with we=1.
  - The WB match also stalls, because the regfile writes at the clock edge.
  - hz causes stall_dec_o=1 and a bubble is loaded into EXEC; the instruction is held in DEC.
- Branch (EXEC): taken = is_branch_exec with condition on func3_exec:
  - BEQ: zero; BNE: !zero
  - BLT: lt; BGE: !lt
  - BLTU: ltu; BGEU: !ltu
- Priority per cycle:
  - 1) Branch taken: pc_next_sel_o=BRANCH, fetch_nop_o=1, stall_dec_o=0, bubble into EXEC (DEC instruction squashed); hz ignored.
  - 2) hz: pc_next_sel_o=PLUS_4, stall_dec_o=1, bubble into EXEC, no jump redirect even if DEC holds JAL/JALR.
  - 3) JAL/JALR in DEC: pc_next_sel_o=JAL/JALR, fetch_nop_o=1, DEC ctrl enters EXEC.
  - 4) Otherwise: PLUS_4, DEC ctrl enters EXEC.
- Pipeline: EXEC to MEM to WB control registers advance every cycle (stall_exec_o=0). Latency from DEC to reg_we_o is 3 cycles.
- Reset mid-operation: all in-flight control is discarded immediately (asynchronous); no partial writes occur after resetn_i falls.

Decomposition:
- RV32i_pkg:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - branch func3 constants
  - ALU_* codes including ALU_COPY1
  - ctrl_t packed struct
  - CTRL_BUBBLE constant
  - existing SEL_* and IMM* encodings
- Sub-module rv32i_decoder: combinational, instruction to ctrl_t.
- Hazard logic, priority logic and stage registers live in the top block.

Test Plan:
- Reset then "addi x1,x0,5" in DEC: after 3 cycles reg_we_o=1, rd_add_o=1, wb_sel_o=SEL_WB_ALU; dmem_we_o=0 throughout.
- "addi x1,x0,5" then "add x2,x1,x1": stall_dec_o=1 for 3 cycles with bubbles in EXEC; add reaches WB 3 cycles after it leaves DEC, with only one write to x2.
- "beq x0,x0,+8" in EXEC with alu_zero_i=1: pc_next_sel_o=SEL_PC_BRANCH, fetch_nop_o=1, the following DEC instruction (addi x3) never asserts reg_we_o.
- "bne" with alu_zero_i=1: not taken, pc_next_sel_o=PLUS_4, no squash.
- "jal x1,+16" in DEC with no hazard: pc_next_sel_o=SEL_PC_JAL, fetch_nop_o=1 for one cycle; 3 cycles later wb_sel_o=SEL_WB_PC_PLUS_4, rd_add_o=1.
- "jalr x0,0(x5)" with x5 written in MEM: stall_dec_o=1 and pc_next_sel_o=PLUS_4 until clear, then JALR is issued. Separately, sw in MEM gives dmem_we_o=1; resetn_i low mid-stream forces dmem_we_o=0 and reg_we_o=0 immediately.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared encodings, control bundle types and small helpers for the RV32I
// pipeline control path.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_COPY1 = 4'd10;

    localparam logic [2:0] SEL_PC_PLUS_4 = 3'd0;
    localparam logic [2:0] SEL_PC_JAL    = 3'd1;
    localparam logic [2:0] SEL_PC_JALR   = 3'd2;
    localparam logic [2:0] SEL_PC_BRANCH = 3'd3;

    localparam logic [1:0] SEL_OP1_RS1 = 2'd0;
    localparam logic [1:0] SEL_OP1_IMM = 2'd1;
    localparam logic [1:0] SEL_OP1_PC  = 2'd2;
    localparam logic       SEL_OP2_RS2 = 1'b0;
    localparam logic       SEL_OP2_IMM = 1'b1;

    localparam logic [2:0] IMM_I  = 3'd0;
    localparam logic [2:0] IMM_S  = 3'd1;
    localparam logic [2:0] IMM_SB = 3'd2;
    localparam logic [2:0] IMM_U  = 3'd3;
    localparam logic [2:0] IMM_UJ = 3'd4;

    localparam logic [1:0] SEL_WB_ALU       = 2'd0;
    localparam logic [1:0] SEL_WB_MEM       = 2'd1;
    localparam logic [1:0] SEL_WB_PC_PLUS_4 = 2'd2;

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] src1;
        logic       src2;
        logic [2:0] imm_sel;
        logic       we;
        logic       dmem_we;
        logic [1:0] wb_sel;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       uses_rs1;
        logic       uses_rs2;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{alu: ALU_ADD, src1: SEL_OP1_RS1, src2: SEL_OP2_RS2,
                                      imm_sel: IMM_I, we: 1'b0, dmem_we: 1'b0,
                                      wb_sel: SEL_WB_ALU, is_branch: 1'b0, is_jal: 1'b0,
                                      is_jalr: 1'b0, uses_rs1: 1'b0, uses_rs2: 1'b0};

    typedef struct packed {
        logic [3:0] alu;
        logic       is_branch;
        logic [2:0] func3;
        logic       we;
        logic       dmem_we;
        logic [1:0] wb_sel;
        logic [4:0] rd;
    } ex_t;

    typedef struct packed {
        logic       we;
        logic       dmem_we;
        logic [1:0] wb_sel;
        logic [4:0] rd;
    } mem_t;

    typedef struct packed {
        logic       we;
        logic [1:0] wb_sel;
        logic [4:0] rd;
    } wb_t;

    localparam ex_t EX_BUBBLE = '{alu: ALU_ADD, is_branch: 1'b0, func3: 3'd0, we: 1'b0,
                                  dmem_we: 1'b0, wb_sel: SEL_WB_ALU, rd: 5'd0};
    localparam mem_t MEM_BUBBLE = '{we: 1'b0, dmem_we: 1'b0, wb_sel: SEL_WB_ALU, rd: 5'd0};
    localparam wb_t WB_BUBBLE = '{we: 1'b0, wb_sel: SEL_WB_ALU, rd: 5'd0};

    // alt selects SUB/SRA over ADD/SRL
    function automatic logic [3:0] alu_op(input logic [2:0] func3, input logic alt);
        logic [3:0] op;
        case (func3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic branch_cond(input logic [2:0] func3, input logic zero,
                                         input logic lt, input logic ltu);
        logic c;
        case (func3)
            F3_BEQ:  c = zero;
            F3_BNE:  c = !zero;
            F3_BLT:  c = lt;
            F3_BGE:  c = !lt;
            F3_BLTU: c = ltu;
            F3_BGEU: c = !ltu;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    function automatic logic reg_match(input logic [4:0] rs, input logic we,
                                       input logic [4:0] rd);
        return we && (rd == rs);
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: DEC-stage instruction to control bundle.
// Unrecognised encodings fall back to a bubble so they behave as NOPs.
module rv32i_decoder
    import rv32i_pkg::*;
(
    input  logic [31:0] instruction,
    output ctrl_t       ctrl
);

    logic [6:0] opcode_s;
    logic [2:0] func3_s;
    logic [6:0] func7_s;
    logic       unused_bits_s;

    assign opcode_s      = instruction[6:0];
    assign func3_s       = instruction[14:12];
    assign func7_s       = instruction[31:25];
    assign unused_bits_s = ^{instruction[24:15], instruction[11:7]};

    // Opcode/func3/func7 to control bundle
    always_comb begin
        ctrl = CTRL_BUBBLE;
        case (opcode_s)
            OPC_OP: begin
                if ((func7_s == 7'b0000000) ||
                    ((func7_s == 7'b0100000) && ((func3_s == 3'b000) || (func3_s == 3'b101)))) begin
                    ctrl.alu      = alu_op(func3_s, func7_s[5]);
                    ctrl.we       = 1'b1;
                    ctrl.uses_rs1 = 1'b1;
                    ctrl.uses_rs2 = 1'b1;
                end else begin
                    ctrl = CTRL_BUBBLE;
                end
            end
            OPC_OP_IMM: begin
                ctrl.alu      = alu_op(func3_s, (func3_s == 3'b101) && func7_s[5]);
                ctrl.src2     = SEL_OP2_IMM;
                ctrl.we       = 1'b1;
                ctrl.uses_rs1 = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.src2     = SEL_OP2_IMM;
                ctrl.we       = 1'b1;
                ctrl.wb_sel   = SEL_WB_MEM;
                ctrl.uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                ctrl.src2     = SEL_OP2_IMM;
                ctrl.imm_sel  = IMM_S;
                ctrl.dmem_we  = 1'b1;
                ctrl.uses_rs1 = 1'b1;
                ctrl.uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                if (func3_s[2:1] != 2'b01) begin
                    ctrl.alu       = ALU_SUB;
                    ctrl.imm_sel   = IMM_SB;
                    ctrl.is_branch = 1'b1;
                    ctrl.uses_rs1  = 1'b1;
                    ctrl.uses_rs2  = 1'b1;
                end else begin
                    ctrl = CTRL_BUBBLE;
                end
            end
            OPC_JAL: begin
                ctrl.imm_sel = IMM_UJ;
                ctrl.we      = 1'b1;
                ctrl.wb_sel  = SEL_WB_PC_PLUS_4;
                ctrl.is_jal  = 1'b1;
            end
            OPC_JALR: begin
                ctrl.src2     = SEL_OP2_IMM;
                ctrl.we       = 1'b1;
                ctrl.wb_sel   = SEL_WB_PC_PLUS_4;
                ctrl.is_jalr  = 1'b1;
                ctrl.uses_rs1 = 1'b1;
            end
            OPC_LUI: begin
                ctrl.alu     = ALU_COPY1;
                ctrl.src1    = SEL_OP1_IMM;
                ctrl.imm_sel = IMM_U;
                ctrl.we      = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.src1    = SEL_OP1_PC;
                ctrl.src2    = SEL_OP2_IMM;
                ctrl.imm_sel = IMM_U;
                ctrl.we      = 1'b1;
            end
            default: ctrl = CTRL_BUBBLE;
        endcase
    end

endmodule

// File: rtl/rv32i_pipeline_controlpath.sv
// Control path for the 4-stage RV32I pipeline: decode, RAW stall, jump/branch
// redirect and the EXEC/MEM/WB control register chain.
module rv32i_pipeline_controlpath
    import rv32i_pkg::*;
#(
    parameter logic [2:0] RESET_PC_SEL = SEL_PC_PLUS_4
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [31:0] instruction_i,
    input  logic        alu_zero_i,
    input  logic        alu_lt_i,
    input  logic        alu_ltu_i,
    output logic        fetch_nop_o,
    output logic        stall_dec_o,
    output logic        stall_exec_o,
    output logic [2:0]  pc_next_sel_o,
    output logic [1:0]  alu_src1_o,
    output logic        alu_src2_o,
    output logic [2:0]  imm_gen_sel_o,
    output logic [3:0]  alu_control_o,
    output logic        dmem_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [4:0]  rd_add_o,
    output logic        reg_we_o
);

    ctrl_t      dec_s;
    ex_t        issue_s;
    ex_t        ex_next_s;
    ex_t        ex_r;
    mem_t       mem_r;
    wb_t        wb_r;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic [4:0] rd_s;
    logic       hz_rs1_s;
    logic       hz_rs2_s;
    logic       hz_s;
    logic       taken_s;
    logic [2:0] pc_sel_s;
    logic       fetch_nop_s;
    logic       stall_dec_s;

    rv32i_decoder u_decoder (
        .instruction (instruction_i),
        .ctrl        (dec_s)
    );

    assign rs1_s = instruction_i[19:15];
    assign rs2_s = instruction_i[24:20];
    assign rd_s  = instruction_i[11:7];

    // A write to x0 is architecturally void, so it never creates a hazard or a regfile write
    assign issue_s = '{alu: dec_s.alu, is_branch: dec_s.is_branch, func3: instruction_i[14:12],
                       we: dec_s.we && (rd_s != 5'd0), dmem_we: dec_s.dmem_we,
                       wb_sel: dec_s.wb_sel, rd: rd_s};

    // WB is included because the regfile only commits at the end of this cycle
    assign hz_rs1_s = dec_s.uses_rs1 && (rs1_s != 5'd0) &&
                      (reg_match(rs1_s, ex_r.we, ex_r.rd) || reg_match(rs1_s, mem_r.we, mem_r.rd) ||
                       reg_match(rs1_s, wb_r.we, wb_r.rd));
    assign hz_rs2_s = dec_s.uses_rs2 && (rs2_s != 5'd0) &&
                      (reg_match(rs2_s, ex_r.we, ex_r.rd) || reg_match(rs2_s, mem_r.we, mem_r.rd) ||
                       reg_match(rs2_s, wb_r.we, wb_r.rd));
    assign hz_s     = hz_rs1_s || hz_rs2_s;
    assign taken_s  = ex_r.is_branch && branch_cond(ex_r.func3, alu_zero_i, alu_lt_i, alu_ltu_i);

    // Per-cycle redirect/stall priority: taken branch, hazard, jump, sequential
    always_comb begin
        pc_sel_s    = SEL_PC_PLUS_4;
        fetch_nop_s = 1'b0;
        stall_dec_s = 1'b0;
        ex_next_s   = EX_BUBBLE;
        if (!resetn_i) begin
            pc_sel_s = RESET_PC_SEL;
        end else if (taken_s) begin
            pc_sel_s    = SEL_PC_BRANCH;
            fetch_nop_s = 1'b1;
        end else if (hz_s) begin
            stall_dec_s = 1'b1;
        end else if (dec_s.is_jal) begin
            pc_sel_s    = SEL_PC_JAL;
            fetch_nop_s = 1'b1;
            ex_next_s   = issue_s;
        end else if (dec_s.is_jalr) begin
            pc_sel_s    = SEL_PC_JALR;
            fetch_nop_s = 1'b1;
            ex_next_s   = issue_s;
        end else begin
            ex_next_s = issue_s;
        end
    end

    // EXEC/MEM/WB control registers; reset discards all in-flight control
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            ex_r  <= EX_BUBBLE;
            mem_r <= MEM_BUBBLE;
            wb_r  <= WB_BUBBLE;
        end else begin
            ex_r  <= ex_next_s;
            mem_r <= '{we: ex_r.we, dmem_we: ex_r.dmem_we, wb_sel: ex_r.wb_sel, rd: ex_r.rd};
            wb_r  <= '{we: mem_r.we, wb_sel: mem_r.wb_sel, rd: mem_r.rd};
        end
    end

    assign pc_next_sel_o = pc_sel_s;
    assign fetch_nop_o   = fetch_nop_s;
    assign stall_dec_o   = stall_dec_s;
    assign stall_exec_o  = 1'b0;
    assign alu_src1_o    = dec_s.src1;
    assign alu_src2_o    = dec_s.src2;
    assign imm_gen_sel_o = dec_s.imm_sel;
    assign alu_control_o = ex_r.alu;
    assign dmem_we_o     = mem_r.dmem_we;
    assign wb_sel_o      = wb_r.wb_sel;
    assign rd_add_o      = wb_r.rd;
    assign reg_we_o      = wb_r.we;

endmodule

// File: tb/tb_rv32i_pipeline_controlpath.sv
// Self-checking bench: expected EXEC/MEM/WB outputs are queued when an
// instruction is issued from DEC and compared when they reach their stage.
module tb_rv32i_pipeline_controlpath;
    import rv32i_pkg::*;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic [31:0] instruction_i;
    logic        alu_zero_i, alu_lt_i, alu_ltu_i;
    logic        fetch_nop_o, stall_dec_o, stall_exec_o;
    logic [2:0]  pc_next_sel_o;
    logic [1:0]  alu_src1_o;
    logic        alu_src2_o;
    logic [2:0]  imm_gen_sel_o;
    logic [3:0]  alu_control_o;
    logic        dmem_we_o;
    logic [1:0]  wb_sel_o;
    logic [4:0]  rd_add_o;
    logic        reg_we_o;

    rv32i_pipeline_controlpath dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .instruction_i(instruction_i),
        .alu_zero_i(alu_zero_i), .alu_lt_i(alu_lt_i), .alu_ltu_i(alu_ltu_i),
        .fetch_nop_o(fetch_nop_o), .stall_dec_o(stall_dec_o), .stall_exec_o(stall_exec_o),
        .pc_next_sel_o(pc_next_sel_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .imm_gen_sel_o(imm_gen_sel_o), .alu_control_o(alu_control_o), .dmem_we_o(dmem_we_o),
        .wb_sel_o(wb_sel_o), .rd_add_o(rd_add_o), .reg_we_o(reg_we_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [31:0] I_IDLE    = 32'h00000000;
    localparam logic [31:0] I_ADDI_X1 = 32'h00500093;
    localparam logic [31:0] I_ADD_X2  = 32'h00108133;
    localparam logic [31:0] I_ADDI_X3 = 32'h00100193;
    localparam logic [31:0] I_ADDI_X5 = 32'h00700293;
    localparam logic [31:0] I_BEQ     = 32'h00000463;
    localparam logic [31:0] I_BNE     = 32'h00001463;
    localparam logic [31:0] I_JAL_X1  = 32'h010000EF;
    localparam logic [31:0] I_JALR_X5 = 32'h00028067;
    localparam logic [31:0] I_SW      = 32'h00112023;
    localparam logic [31:0] I_LW_X4   = 32'h00002203;
    localparam logic [31:0] I_LUI_X6  = 32'h12345337;

    typedef struct packed {
        logic       we;
        logic [4:0] rd;
        logic [1:0] wb_sel;
        logic       dmem_we;
        logic [3:0] alu;
        logic       bub;
    } exp_t;

    localparam exp_t EXP_BUB = '{we: 1'b0, rd: 5'd0, wb_sel: SEL_WB_ALU, dmem_we: 1'b0,
                                 alu: ALU_ADD, bub: 1'b1};

    exp_t  wbq[$];
    exp_t  memq[$];
    exp_t  exq[$];
    int    checks = 0;
    int    errors = 0;
    string cur_test = "";

    // Reference expectations for the handful of instructions used here
    function automatic exp_t mdl(input logic [31:0] ins);
        exp_t e;
        logic [6:0] op;
        op = ins[6:0];
        e = '{we: 1'b0, rd: ins[11:7], wb_sel: SEL_WB_ALU, dmem_we: 1'b0, alu: ALU_ADD, bub: 1'b0};
        case (op)
            7'h13: e.we = 1'b1;
            7'h33: begin e.we = 1'b1; e.alu = ins[30] ? ALU_SUB : ALU_ADD; end
            7'h37: begin e.we = 1'b1; e.alu = ALU_COPY1; end
            7'h03: begin e.we = 1'b1; e.wb_sel = SEL_WB_MEM; end
            7'h23: e.dmem_we = 1'b1;
            7'h63: e.alu = ALU_SUB;
            7'h6f, 7'h67: begin e.we = 1'b1; e.wb_sel = SEL_WB_PC_PLUS_4; end
            default: e.we = 1'b0;
        endcase
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    task automatic init_q();
        wbq.delete(); memq.delete(); exq.delete();
        repeat (3) wbq.push_back(EXP_BUB);
        repeat (2) memq.push_back(EXP_BUB);
        exq.push_back(EXP_BUB);
    endtask

    // One clock: drive DEC inputs, check DEC-side outputs, pop/check stage outputs, push issue
    task automatic cyc(input logic [31:0] ins, input logic z, input logic lt, input logic ltu,
                       input logic issue, input logic [2:0] e_sel, input logic e_stall,
                       input logic e_nop);
        exp_t w, m, x;
        @(posedge clk_i); #1;
        instruction_i = ins; alu_zero_i = z; alu_lt_i = lt; alu_ltu_i = ltu;
        @(negedge clk_i);
        checks++;
        if (stall_dec_o !== e_stall) begin
            errors++; $display("FAIL %s stall_dec got %b exp %b t=%0t", cur_test, stall_dec_o, e_stall, $time);
        end
        checks++;
        if (pc_next_sel_o !== e_sel) begin
            errors++; $display("FAIL %s pc_next_sel got %0d exp %0d t=%0t", cur_test, pc_next_sel_o, e_sel, $time);
        end
        checks++;
        if (fetch_nop_o !== e_nop) begin
            errors++; $display("FAIL %s fetch_nop got %b exp %b t=%0t", cur_test, fetch_nop_o, e_nop, $time);
        end
        checks++;
        if (stall_exec_o !== 1'b0) begin
            errors++; $display("FAIL %s stall_exec got %b exp 0 t=%0t", cur_test, stall_exec_o, $time);
        end
        w = wbq.pop_front();
        checks++;
        if (reg_we_o !== w.we) begin
            errors++; $display("FAIL %s reg_we got %b exp %b t=%0t", cur_test, reg_we_o, w.we, $time);
        end
        if (w.we || w.bub) begin
            checks++;
            if (rd_add_o !== w.rd) begin
                errors++; $display("FAIL %s rd_add got %0d exp %0d t=%0t", cur_test, rd_add_o, w.rd, $time);
            end
            checks++;
            if (wb_sel_o !== w.wb_sel) begin
                errors++; $display("FAIL %s wb_sel got %0d exp %0d t=%0t", cur_test, wb_sel_o, w.wb_sel, $time);
            end
        end
        m = memq.pop_front();
        checks++;
        if (dmem_we_o !== m.dmem_we) begin
            errors++; $display("FAIL %s dmem_we got %b exp %b t=%0t", cur_test, dmem_we_o, m.dmem_we, $time);
        end
        x = exq.pop_front();
        checks++;
        if (alu_control_o !== x.alu) begin
            errors++; $display("FAIL %s alu_control got %0d exp %0d t=%0t", cur_test, alu_control_o, x.alu, $time);
        end
        w = issue ? mdl(ins) : EXP_BUB;
        wbq.push_back(w); memq.push_back(w); exq.push_back(w);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(I_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cur_test = "reset";
        resetn_i = 1'b0; instruction_i = I_JAL_X1;
        alu_zero_i = 1'b0; alu_lt_i = 1'b0; alu_ltu_i = 1'b0;
        #2;
        checks += 8;
        if (dmem_we_o !== 1'b0) begin errors++; $display("FAIL reset dmem_we got %b exp 0", dmem_we_o); end
        if (reg_we_o !== 1'b0) begin errors++; $display("FAIL reset reg_we got %b exp 0", reg_we_o); end
        if (rd_add_o !== 5'd0) begin errors++; $display("FAIL reset rd_add got %0d exp 0", rd_add_o); end
        if (alu_control_o !== ALU_ADD) begin errors++; $display("FAIL reset alu_control got %0d exp %0d", alu_control_o, ALU_ADD); end
        if (stall_exec_o !== 1'b0) begin errors++; $display("FAIL reset stall_exec got %b exp 0", stall_exec_o); end
        if (pc_next_sel_o !== SEL_PC_PLUS_4) begin errors++; $display("FAIL reset pc_next_sel got %0d exp %0d", pc_next_sel_o, SEL_PC_PLUS_4); end
        if (stall_dec_o !== 1'b0) begin errors++; $display("FAIL reset stall_dec got %b exp 0", stall_dec_o); end
        if (fetch_nop_o !== 1'b0) begin errors++; $display("FAIL reset fetch_nop got %b exp 0", fetch_nop_o); end
        @(negedge clk_i);
        resetn_i = 1'b1; instruction_i = I_IDLE;
        init_q();
    endtask

    task automatic test_addi();
        cur_test = "addi";
        cyc(I_ADDI_X1, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic test_raw();
        cur_test = "raw_stall";
        cyc(I_ADDI_X1, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        repeat (3) cyc(I_ADD_X2, 1'b0, 1'b0, 1'b0, 1'b0, SEL_PC_PLUS_4, 1'b1, 1'b0);
        cyc(I_ADD_X2, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic test_branches();
        logic [31:0] br [6];
        logic        z [6];
        logic        lt [6];
        logic        ltu [6];
        logic        tk [6];
        br = '{I_BEQ, I_BNE, 32'h00004463, 32'h00005463, 32'h00006463, 32'h00007463};
        z   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        lt  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ltu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tk  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            cur_test = $sformatf("branch%0d", i);
            cyc(br[i], 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
            cyc(I_ADDI_X3, z[i], lt[i], ltu[i], !tk[i],
                tk[i] ? SEL_PC_BRANCH : SEL_PC_PLUS_4, 1'b0, tk[i]);
        end
        idle(3);
    endtask

    task automatic test_branch_over_hazard();
        cur_test = "branch_over_hz";
        cyc(I_ADDI_X1, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        cyc(I_BEQ, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        cyc(I_ADD_X2, 1'b1, 1'b0, 1'b0, 1'b0, SEL_PC_BRANCH, 1'b0, 1'b1);
        idle(3);
    endtask

    task automatic test_jal();
        cur_test = "jal";
        cyc(I_JAL_X1, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_JAL, 1'b0, 1'b1);
        idle(3);
    endtask

    task automatic test_jalr_hazard();
        cur_test = "jalr_hz";
        cyc(I_ADDI_X5, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        cyc(I_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        repeat (2) cyc(I_JALR_X5, 1'b0, 1'b0, 1'b0, 1'b0, SEL_PC_PLUS_4, 1'b1, 1'b0);
        cyc(I_JALR_X5, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_JALR, 1'b0, 1'b1);
        idle(3);
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        cyc(I_ADDI_X3, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        cyc(I_ADDI_X5, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        cyc(I_LUI_X6, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        cyc(I_ADDI_X1, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic test_mem_reset();
        cur_test = "mem_reset";
        cyc(I_LUI_X6, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        checks += 2;
        if (alu_src1_o !== SEL_OP1_IMM) begin errors++; $display("FAIL lui alu_src1 got %0d exp %0d", alu_src1_o, SEL_OP1_IMM); end
        if (imm_gen_sel_o !== IMM_U) begin errors++; $display("FAIL lui imm_sel got %0d exp %0d", imm_gen_sel_o, IMM_U); end
        cyc(I_SW, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        checks += 2;
        if (alu_src2_o !== SEL_OP2_IMM) begin errors++; $display("FAIL sw alu_src2 got %0d exp %0d", alu_src2_o, SEL_OP2_IMM); end
        if (imm_gen_sel_o !== IMM_S) begin errors++; $display("FAIL sw imm_sel got %0d exp %0d", imm_gen_sel_o, IMM_S); end
        cyc(I_LW_X4, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        cyc(I_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, SEL_PC_PLUS_4, 1'b0, 1'b0);
        #1 resetn_i = 1'b0;
        #1;
        checks += 3;
        if (dmem_we_o !== 1'b0) begin errors++; $display("FAIL midreset dmem_we got %b exp 0", dmem_we_o); end
        if (reg_we_o !== 1'b0) begin errors++; $display("FAIL midreset reg_we got %b exp 0", reg_we_o); end
        if (alu_control_o !== ALU_ADD) begin errors++; $display("FAIL midreset alu_control got %0d exp %0d", alu_control_o, ALU_ADD); end
        @(posedge clk_i); #1;
        checks += 2;
        if (dmem_we_o !== 1'b0) begin errors++; $display("FAIL inreset dmem_we got %b exp 0", dmem_we_o); end
        if (reg_we_o !== 1'b0) begin errors++; $display("FAIL inreset reg_we got %b exp 0", reg_we_o); end
        @(negedge clk_i);
        resetn_i = 1'b1; instruction_i = I_IDLE;
        init_q();
        idle(2);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_raw();
        test_branches();
        test_branch_over_hazard();
        test_jal();
        test_jalr_hazard();
        test_back_to_back();
        test_mem_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
